fp_addsub_pipe: RTL and testbench

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

---
 rtl/fp_addsub_pipe.sv | 248 ++++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe -- four-stage pipelined floating-point adder/subtractor.
//
// Stages (one register bank each, all moving together on 'advance'):
//   S1  unpack, flush denormals, magnitude compare, swap, align shift with sticky
//   S2  signed mantissa add/sub (larger magnitude minus smaller, never negative)
//   S3  carry renormalise or leading-zero normalise, underflow flush to +0
//   S4  round (optional), overflow saturation, pack, flags -> output register
// advance = out_ready || !out_valid, and in_ready = advance, so a full output
// register with a stalled consumer freezes the whole pipe.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand set present          in_ready   operands accepted this cycle
//   f          0 = A+B, 1 = A-B
//   A, B       operands {sign, exponent[EXP_W], fraction[MAN_W]}
//   out_valid  result present               out_ready  consumer accepts result
//   S          result
//   out_ovf    result saturated to infinity
//   out_zero   result is zero
//
// Build option: define FP_ADDSUB_ROUND_EN for round-to-nearest-even in S4;
// left undefined, the result is truncated and guard/round/sticky are dropped.

module fp_addsub_pipe #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         f,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] S,
   output logic         out_ovf,
   output logic         out_zero
);

   localparam int MW  = MAN_W + 4;          // hidden, fraction, guard, round, sticky
   localparam int EW  = EXP_W + 2;          // exponent headroom for +1 carries
   localparam int LZW = $clog2(MW + 1);
   localparam int RW  = MAN_W + 2;          // rounding adder: carry, hidden, fraction
`ifdef FP_ADDSUB_ROUND_EN
   localparam int KEEP = 0;                 // guard/round/sticky carried into S4
`else
   localparam int KEEP = 3;                 // truncation: guard/round/sticky dropped after S3
`endif
   localparam int NW  = MW - KEEP;
   localparam int LSB = NW - 1 - MAN_W;     // position of the fraction LSB in s3_man
   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   typedef enum logic [1:0] {SP_NONE, SP_INF, SP_NAN} special_e;

   logic advance;
   assign advance  = out_ready || !out_valid;
   assign in_ready = advance;

   // ---------------- S1: compare, swap, align ----------------
   logic [EXP_W-1:0] a_exp, b_exp, exp_l, exp_s, exp_diff;
   logic [W-2:0]     a_mag, b_mag;
   logic [MW-1:0]    a_man, b_man, man_l, man_s, man_s_al;
   logic             a_zero, b_zero, a_inf, b_inf, b_sign, swap, sign_l, sub1, sticky1;
   logic             spec_sign1;
   special_e         spec1;

   always_comb begin
      // NOTE: every variable is assigned before any branch reads or skips it, so
      // no path through the block leaves a value to be remembered (no latch).
      a_exp    = A[W-2:MAN_W];
      b_exp    = B[W-2:MAN_W];
      b_sign   = B[W-1] ^ f;
      a_zero   = (a_exp == '0);
      b_zero   = (b_exp == '0);
      a_inf    = (a_exp == EXP_ONES);
      b_inf    = (b_exp == EXP_ONES);
      // Denormals compare and add as true zero
      a_mag    = a_zero ? '0 : A[W-2:0];
      b_mag    = b_zero ? '0 : B[W-2:0];
      a_man    = a_zero ? '0 : {1'b1, A[MAN_W-1:0], 3'b000};
      b_man    = b_zero ? '0 : {1'b1, B[MAN_W-1:0], 3'b000};
      swap     = (b_mag > a_mag);
      exp_l    = swap ? b_exp : a_exp;
      exp_s    = swap ? a_exp : b_exp;
      man_l    = swap ? b_man : a_man;
      man_s    = swap ? a_man : b_man;
      sign_l   = swap ? b_sign : A[W-1];
      sub1     = A[W-1] ^ b_sign;
      exp_diff = exp_l - exp_s;
      sticky1  = 1'b0;
      man_s_al = '0;
      if (int'(exp_diff) >= MW - 1) begin
         // Shift reaches past guard and round: only the sticky bit survives
         man_s_al[0] = |man_s;
      end else begin
         for (int i = 0; i < MW; i++)
            if (i < int'(exp_diff)) sticky1 = sticky1 | man_s[i];
         man_s_al    = man_s >> exp_diff;
         man_s_al[0] = man_s_al[0] | sticky1;
      end
      spec1      = SP_NONE;
      spec_sign1 = 1'b0;
      if (a_inf && b_inf && (A[W-1] != b_sign)) begin
         spec1 = SP_NAN;
      end else if (a_inf) begin
         spec1      = SP_INF;
         spec_sign1 = A[W-1];
      end else if (b_inf) begin
         spec1      = SP_INF;
         spec_sign1 = b_sign;
      end
   end

   logic             s1_valid, s1_sign, s1_sub, s1_spec_sign;
   logic [EXP_W-1:0] s1_exp;
   logic [MW-1:0]    s1_man_l, s1_man_s;
   special_e         s1_spec;

   // ---------------- S2: add / subtract ----------------
   // The swap guarantees man_l >= man_s, so the difference is never negative.
   logic [MW:0] sum2;
   assign sum2 = s1_sub ? ({1'b0, s1_man_l} - {1'b0, s1_man_s})
                        : ({1'b0, s1_man_l} + {1'b0, s1_man_s});

   logic             s2_valid, s2_sign, s2_spec_sign;
   logic [EXP_W-1:0] s2_exp;
   logic [MW:0]      s2_sum;
   special_e         s2_spec;

   // ---------------- S3: normalise ----------------
   logic [LZW-1:0] lz;
   logic [MW-1:0]  norm3;
   logic [EW-1:0]  exp3;
   logic           zero3;

   always_comb begin
      lz = LZW'(MW);
      for (int i = 0; i < MW; i++)
         if (s2_sum[i]) lz = LZW'(MW - 1 - i);
      norm3 = '0;
      exp3  = '0;
      zero3 = 1'b0;
      if (s2_sum[MW]) begin
         // Carry out: shift right one, folding the lost bit into sticky
         norm3 = {s2_sum[MW:2], s2_sum[1] | s2_sum[0]};
         exp3  = EW'(s2_exp) + EW'(1);
      end else if ((s2_sum[MW-1:0] == '0) || (EW'(s2_exp) <= EW'(lz))) begin
         // Exact cancellation, or the normalised exponent would fall below 1
         zero3 = 1'b1;
      end else begin
         norm3 = s2_sum[MW-1:0] << lz;
         exp3  = EW'(s2_exp) - EW'(lz);
      end
   end

   logic           s3_valid, s3_sign, s3_zero, s3_spec_sign;
   logic [EW-1:0]  s3_exp;
   logic [NW-1:0]  s3_man;
   special_e       s3_spec;

   // ---------------- S4: round, pack, flags ----------------
   logic             round_up, ovf4, zero4;
   logic [RW-1:0]    mant4;
   logic [EW-1:0]    exp4;
   logic [MAN_W-1:0] frac4;
   logic [W-1:0]     s4;

   always_comb begin
`ifdef FP_ADDSUB_ROUND_EN
      // Nearest-even: round up above half, or at exactly half when LSB is odd
      round_up = s3_man[2] & (s3_man[1] | s3_man[0] | s3_man[3]);
`else
      round_up = 1'b0;
`endif
      mant4 = {1'b0, s3_man[NW-1:LSB]} + RW'(round_up);
      // A rounding carry means the mantissa became 10.000..0: bump the exponent
      exp4  = s3_exp + EW'(mant4[RW-1]);
      frac4 = mant4[RW-1] ? mant4[MAN_W:1] : mant4[MAN_W-1:0];
      s4    = '0;
      ovf4  = 1'b0;
      zero4 = 1'b0;
      case (s3_spec)
         SP_NAN:  s4 = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
         SP_INF:  s4 = {s3_spec_sign, EXP_ONES, {MAN_W{1'b0}}};
         default: begin
            if (s3_zero) begin
               zero4 = 1'b1;
            end else if (exp4 >= EW'(EXP_ONES)) begin
               s4   = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
               ovf4 = 1'b1;
            end else begin
               s4 = {s3_sign, exp4[EXP_W-1:0], frac4};
            end
         end
      endcase
   end

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0; s1_sign <= 1'b0; s1_sub <= 1'b0; s1_spec_sign <= 1'b0;
         s1_exp   <= '0;   s1_man_l <= '0;  s1_man_s <= '0; s1_spec <= SP_NONE;
         s2_valid <= 1'b0; s2_sign <= 1'b0; s2_spec_sign <= 1'b0;
         s2_exp   <= '0;   s2_sum  <= '0;   s2_spec <= SP_NONE;
         s3_valid <= 1'b0; s3_sign <= 1'b0; s3_zero <= 1'b0; s3_spec_sign <= 1'b0;
         s3_exp   <= '0;   s3_man  <= '0;   s3_spec <= SP_NONE;
         out_valid <= 1'b0; S <= '0; out_ovf <= 1'b0; out_zero <= 1'b0;
      end else if (advance) begin
         // NOTE: non-blocking assignments so every stage captures the value its
         // predecessor held before this edge, whatever order the lines appear in.
         s1_valid     <= in_valid;
         s1_sign      <= sign_l;
         s1_sub       <= sub1;
         s1_exp       <= exp_l;
         s1_man_l     <= man_l;
         s1_man_s     <= man_s_al;
         s1_spec      <= spec1;
         s1_spec_sign <= spec_sign1;

         s2_valid     <= s1_valid;
         s2_sign      <= s1_sign;
         s2_exp       <= s1_exp;
         s2_sum       <= sum2;
         s2_spec      <= s1_spec;
         s2_spec_sign <= s1_spec_sign;

         s3_valid     <= s2_valid;
         s3_sign      <= s2_sign;
         s3_zero      <= zero3;
         s3_exp       <= exp3;
         s3_man       <= NW'(norm3 >> KEEP);
         s3_spec      <= s2_spec;
         s3_spec_sign <= s2_spec_sign;

         out_valid <= s3_valid;
         if (s3_valid) begin
            S        <= s4;
            out_ovf  <= ovf4;
            out_zero <= zero4;
         end
      end
   end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe -- directed bench for fp_addsub_pipe (EXP_W=8, MAN_W=23).
// Expected results are hand-computed single-precision constants.

module tb_fp_addsub_pipe;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, f, out_valid, out_ready, out_ovf, out_zero;
   logic [W-1:0] A, B, S;

   int checks = 0;
   int errors = 0;

   int   idx_in, idx_out, cyc, seen;
   logic acc_in, acc_out;
   logic [W-1:0] flt [0:11];
   logic [W-1:0] stream_exp [0:9];

   always #5 clk = ~clk;

   fp_addsub_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .f         (f),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One operation through an otherwise empty pipe; returns with the result consumed.
   task automatic run_op(input string tag, input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_s,
                         input logic exp_ovf, input logic exp_zero);
      int lat;
      A = a; B = b; f = op; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check({tag, " in_ready"}, W'(in_ready), W'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, W'(lat), W'(4));
      check({tag, " S"}, S, exp_s);
      check({tag, " ovf"}, W'(out_ovf), W'(exp_ovf));
      check({tag, " zero"}, W'(out_zero), W'(exp_zero));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; f = 1'b0; A = '0; B = '0;
      flt = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
              32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
              32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000};
      // Stream item i: A = i+1, B = 1.0, f = i[0]
      for (int i = 0; i < 10; i++) stream_exp[i] = (i % 2 == 1) ? flt[i] : flt[i + 2];

      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", W'(out_valid), W'(0));
      check("reset S", S, W'(0));
      check("reset ovf", W'(out_ovf), W'(0));
      check("reset zero", W'(out_zero), W'(0));
      check("reset in_ready", W'(in_ready), W'(1));
      rst = 1'b0;

      run_op("1+1",        1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
      run_op("3-1",        1'b1, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
      run_op("1-1",        1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b1);
      run_op("max+max",    1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0);
`ifdef FP_ADDSUB_ROUND_EN
      run_op("grs above",  1'b0, 32'h3F800000, 32'h33C00000, 32'h3F800001, 1'b0, 1'b0);
      run_op("round carry",1'b0, 32'h3FFFFFFF, 32'h33800000, 32'h40000000, 1'b0, 1'b0);
`else
      run_op("grs above",  1'b0, 32'h3F800000, 32'h33C00000, 32'h3F800000, 1'b0, 1'b0);
      run_op("round carry",1'b0, 32'h3FFFFFFF, 32'h33800000, 32'h3FFFFFFF, 1'b0, 1'b0);
`endif
      run_op("grs tie",    1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0);
      run_op("1+0.5",      1'b0, 32'h3F800000, 32'h3F000000, 32'h3FC00000, 1'b0, 1'b0);
      run_op("1-0.75",     1'b1, 32'h3F800000, 32'h3F400000, 32'h3E800000, 1'b0, 1'b0);
      run_op("-2+0.5",     1'b0, 32'hC0000000, 32'h3F000000, 32'hBFC00000, 1'b0, 1'b0);
      run_op("underflow",  1'b1, 32'h00800000, 32'h00C00000, 32'h00000000, 1'b0, 1'b1);
      run_op("sticky only",1'b0, 32'h3F800000, 32'h00800000, 32'h3F800000, 1'b0, 1'b0);
      run_op("pi-0",       1'b1, 32'h40490FDB, 32'h00000000, 32'h40490FDB, 1'b0, 1'b0);
      run_op("0-1",        1'b1, 32'h00000000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0);
      run_op("inf+1",      1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b0);
      run_op("inf-inf",    1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b0);

      // Ten back-to-back operands with out_ready low for cycles 6..8
      idx_in = 0; idx_out = 0; cyc = 0;
      while (idx_out < 10 && cyc < 60) begin
         out_ready = !(cyc >= 6 && cyc <= 8);
         in_valid  = (idx_in < 10);
         if (idx_in < 10) begin
            A = flt[idx_in + 1];
            B = flt[1];
            f = idx_in[0];
         end
         #1;
         acc_in  = in_valid && in_ready;
         acc_out = out_valid && out_ready;
         if (!out_ready) begin
            check("stall in_ready", W'(in_ready), W'(0));
            check("stall out_valid", W'(out_valid), W'(1));
            check("stall S hold", S, stream_exp[idx_out]);
         end
         if (acc_out) begin
            check($sformatf("stream S[%0d]", idx_out), S, stream_exp[idx_out]);
            idx_out++;
         end
         @(posedge clk); #1;
         if (acc_in) idx_in++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream results", W'(idx_out), W'(10));
      check("stream accepted", W'(idx_in), W'(10));
      check("stream drained", W'(out_valid), W'(0));

      // Reset with work in flight: 1+1, 2+1, 3+1, 4+1 accepted on consecutive edges
      for (int i = 0; i < 4; i++) begin
         A = flt[i + 1]; B = flt[1]; f = 1'b0; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("pre-rst out_valid", W'(out_valid), W'(1));
      check("pre-rst S", S, 32'h40000000);
      rst = 1'b1;
      #1;
      check("rst out_valid", W'(out_valid), W'(0));
      check("rst S", S, W'(0));
      check("rst in_ready", W'(in_ready), W'(1));
      @(posedge clk); #1;
      rst  = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("no stale after rst", W'(seen), W'(0));
      run_op("post-rst 3+1", 1'b0, 32'h40400000, 32'h3F800000, 32'h40800000, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
